// File: rtl/prefetch_fetch_unit.sv
// -----------------------------------------------------------------------------
// prefetch_fetch_unit
//
// Instruction prefetch unit. It issues sequential word fetches to an
// instruction memory over a req/gnt + rvalid protocol. Responses are kept in a
// small prefetch FIFO that the IF/ID stage drains with a valid/ready handshake.
// A branch redirect flushes the FIFO, drops every response still in flight for
// the old stream, and restarts fetching at the branch target.
//
// Build option:
//   FETCH_BYPASS_EN - when defined, an accepted response that arrives while the
//                     FIFO is empty is also presented on the instruction outputs
//                     in the same cycle. If the consumer takes it in that cycle
//                     it is not written into the FIFO.
//                     When undefined, every instruction passes through the FIFO
//                     (one cycle from rvalid to instr_valid_o).
//
// Parameters:
//   WORD_WIDTH      - instruction and address width
//   FIFO_DEPTH      - prefetch FIFO entries (power of two, >= 2)
//   MAX_OUTSTANDING - granted requests allowed without a response (1..FIFO_DEPTH)
//
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   fetch_en_i          - enable fetching
//   pc_start_addr_i     - first fetch address, loaded when leaving IDLE
//   branch_i            - redirect strobe
//   branch_addr_i       - redirect target
//   instr_req_o         - memory request (held until instr_gnt_i)
//   instr_addr_o        - request address (held until instr_gnt_i)
//   instr_gnt_i         - memory accepted the request
//   instr_rvalid_i      - response valid (responses return in request order)
//   instr_rdata_i       - response data
//   instr_valid_o       - an instruction is available
//   instr_rdata_o       - instruction to the IF/ID register
//   instr_pc_o          - PC of instr_rdata_o
//   instr_ready_i       - consumer takes the instruction when valid & ready
//   busy_o              - FSM not IDLE or responses still outstanding
// -----------------------------------------------------------------------------
module prefetch_fetch_unit #(
    parameter int WORD_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  instr_valid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    output logic [WORD_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    output logic                  busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PQ_W-1:0]  PQ_LAST   = PQ_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;  // address of the next new request
    logic                    req_q, req_d;
    logic [WORD_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        outst_q, outst_d;
    logic [CNT_W-1:0]        discard_q, discard_d;
    logic                    pend_disc_q, pend_disc_d;    // held request belongs to a flushed stream
    logic                    busy_q, busy_d;

    logic [WORD_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    // PCs of granted requests, in order, waiting for their response
    logic [WORD_WIDTH-1:0]   pcq_q [MAX_OUTSTANDING];
    logic [PQ_W-1:0]         pcq_wr_q, pcq_wr_d;
    logic [PQ_W-1:0]         pcq_rd_q, pcq_rd_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                  gnt_fire;
    logic                  hold;
    logic                  rsp_fire;
    logic                  rsp_keep;
    logic [WORD_WIDTH-1:0] rsp_pc;
    logic                  fifo_empty;
    logic                  bypass_act;
    logic                  push_fifo;
    logic                  pop_fifo;
    logic [WORD_WIDTH-1:0] fetch_n;
    logic [CNT_W:0]        occ_d;
    logic                  can_issue;

    assign gnt_fire   = req_q && instr_gnt_i;
    assign hold       = req_q && !instr_gnt_i;
    // A response with nothing outstanding (e.g. one that belonged to a request
    // abandoned by reset) is ignored entirely.
    assign rsp_fire   = instr_rvalid_i && (outst_q != '0);
    // Responses arriving in the branch cycle belong to the old stream.
    assign rsp_keep   = rsp_fire && (discard_q == '0) && !branch_i;
    assign rsp_pc     = pcq_q[pcq_rd_q];
    assign fifo_empty = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_act = fifo_empty && rsp_keep;
`else
    assign bypass_act = 1'b0;
`endif

    // An instruction taken straight off the bypass path never enters the FIFO.
    assign push_fifo  = rsp_keep && !(bypass_act && instr_ready_i);
    // The flush in a branch cycle overrides any pop.
    assign pop_fifo   = !fifo_empty && instr_ready_i && !branch_i;

    // ------------------------------------------------------------------
    // Instruction outputs
    // ------------------------------------------------------------------
    // Data/PC are forced to zero while nothing is valid so that the
    // unreset FIFO storage never leaks onto the outputs.
    assign instr_valid_o = !fifo_empty || bypass_act;

    always_comb begin
        // NOTE: every signal driven in an always_comb gets a default first so
        // no path can leave it unassigned and infer a latch.
        instr_rdata_o = '0;
        instr_pc_o    = '0;
        if (!fifo_empty) begin
            instr_rdata_o = fifo_data_q[rd_ptr_q];
            instr_pc_o    = fifo_pc_q[rd_ptr_q];
        end else if (bypass_act) begin
            instr_rdata_o = instr_rdata_i;
            instr_pc_o    = rsp_pc;
        end
    end

    assign instr_req_o  = req_q;
    assign instr_addr_o = addr_q;
    assign busy_o       = busy_q;

    // ------------------------------------------------------------------
    // FIFO and in-flight PC queue bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_fifo);
        if (branch_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_fifo);
            count_d  = count_q + CNT_W'(push_fifo) - CNT_W'(pop_fifo);
        end

        pcq_wr_d = pcq_wr_q;
        if (gnt_fire) begin
            pcq_wr_d = (pcq_wr_q == PQ_LAST) ? '0 : pcq_wr_q + PQ_W'(1);
        end
        pcq_rd_d = pcq_rd_q;
        if (rsp_fire) begin
            pcq_rd_d = (pcq_rd_q == PQ_LAST) ? '0 : pcq_rd_q + PQ_W'(1);
        end

        outst_d = outst_q + CNT_W'(gnt_fire) - CNT_W'(rsp_fire);
    end

    // ------------------------------------------------------------------
    // Discard accounting
    // ------------------------------------------------------------------
    // On a branch everything outstanding after this cycle belongs to the old
    // stream, which is exactly outst_d. A request still waiting for its grant
    // is remembered and added to the discard count once it is granted.
    always_comb begin
        if (branch_i) begin
            discard_d   = outst_d;
            pend_disc_d = hold;
        end else begin
            discard_d   = discard_q
                        - CNT_W'(rsp_fire && (discard_q != '0))
                        + CNT_W'(gnt_fire && pend_disc_q);
            pend_disc_d = pend_disc_q && !gnt_fire;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM next state and request generation
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        fetch_n = fetch_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fetch_en_i) begin
                    state_d = ST_FETCH;
                    fetch_n = pc_start_addr_i;
                end
            end
            ST_FETCH: begin
                // A redirect keeps the unit fetching this cycle; a pending
                // request must be granted before fetching can stop.
                if (!branch_i && !fetch_en_i && !hold) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (branch_i) begin
            fetch_n = branch_addr_i;
        end

        // Reserve FIFO space for every in-flight response so a full FIFO can
        // never be overrun.
        occ_d     = {1'b0, outst_d} + {1'b0, count_d};
        can_issue = (state_d == ST_FETCH) && (discard_d == '0) && !pend_disc_d
                 && (occ_d < DEPTH_OCC) && (outst_d < MAX_OUT);

        req_d        = 1'b0;
        addr_d       = addr_q;
        fetch_addr_d = fetch_n;
        if (hold) begin
            req_d = 1'b1;
        end else if (can_issue) begin
            req_d        = 1'b1;
            addr_d       = fetch_n;
            fetch_addr_d = fetch_n + WORD_WIDTH'(4);
        end

        busy_d = (state_d != ST_IDLE) || (outst_d != '0);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            pend_disc_q  <= 1'b0;
            busy_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pcq_wr_q     <= '0;
            pcq_rd_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            pend_disc_q  <= pend_disc_d;
            busy_q       <= busy_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pcq_wr_q     <= pcq_wr_d;
            pcq_rd_q     <= pcq_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage arrays
    // ------------------------------------------------------------------
    // NOTE: the storage arrays have no reset; the pointers and counters are
    // reset, and nothing reads an entry before it has been written.
    always_ff @(posedge clk) begin
        if (push_fifo) begin
            fifo_data_q[wr_ptr_q] <= instr_rdata_i;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc;
        end
        if (gnt_fire) begin
            pcq_q[pcq_wr_q] <= addr_q;
        end
    end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_prefetch_fetch_unit
//
// Self-checking bench for prefetch_fetch_unit. A memory responder grants
// requests and returns mem_f(addr) in order after a per-request latency. The
// reference model is the program stream itself: instructions must be delivered
// at consecutive PCs from the start address, restarting at the branch target
// after every redirect, each carrying mem_f(pc). Directed phases cover reset,
// throughput, back-pressure, drain, redirect corner cases, address wrap and
// reset with responses in flight; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_prefetch_fetch_unit;

    localparam int W    = 32;
    localparam int MAXO = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_en_i;
    logic [W-1:0] pc_start_addr_i;
    logic         branch_i;
    logic [W-1:0] branch_addr_i;
    logic         instr_req_o;
    logic [W-1:0] instr_addr_o;
    logic         instr_gnt_i;
    logic         instr_rvalid_i;
    logic [W-1:0] instr_rdata_i;
    logic         instr_valid_o;
    logic [W-1:0] instr_rdata_o;
    logic [W-1:0] instr_pc_o;
    logic         instr_ready_i;
    logic         busy_o;

    always #5 clk = ~clk;

    prefetch_fetch_unit #(
        .WORD_WIDTH     (W),
        .FIFO_DEPTH     (4),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en_i     (fetch_en_i),
        .pc_start_addr_i(pc_start_addr_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_pc_o     (instr_pc_o),
        .instr_ready_i  (instr_ready_i),
        .busy_o         (busy_o)
    );

    typedef struct packed {
        logic [W-1:0] addr;
        int           due;
    } rsp_t;

    rsp_t         mq[$];          // granted requests awaiting a response
    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;

    // stimulus knobs
    bit           gnt_always;
    int           lat_min, lat_max;
    int           ready_mode;     // 0: never, 1: always, 2: random
    bit           br_req;
    logic [W-1:0] br_tgt;
    bit           rst_req;
    bit           en;
    logic [W-1:0] start_pc;

    // reference model / observation state
    logic [W-1:0] exp_pc;
    int           deliveries;
    int           grants;
    logic [W-1:0] last_pc;
    bit           prev_hold;
    logic [W-1:0] prev_addr;
    bit           rv_seen;
    logic         valid_at_rv;

    function automatic logic [W-1:0] mem_f(input logic [W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, evaluate the
    // handshakes that the next rising edge will commit, then advance.
    task automatic tick();
        bit   send;
        rsp_t r;
        @(negedge clk);
        rst             = rst_req;
        fetch_en_i      = en;
        pc_start_addr_i = start_pc;
        branch_i        = br_req;
        branch_addr_i   = br_tgt;
        instr_gnt_i     = !rst_req && instr_req_o && (gnt_always || ($urandom_range(0, 3) != 0));
        send            = (mq.size() > 0) && (mq[0].due <= cyc);
        instr_rvalid_i  = send;
        instr_rdata_i   = send ? mem_f(mq[0].addr) : $urandom();
        case (ready_mode)
            0:       instr_ready_i = 1'b0;
            1:       instr_ready_i = 1'b1;
            default: instr_ready_i = ($urandom_range(0, 1) == 1);
        endcase
        #1;
        if (!rst_req) begin
            if (prev_hold) begin
                check("req_held", 32'(instr_req_o), 32'd1);
                check("addr_held", instr_addr_o, prev_addr);
            end
            if (instr_valid_o && instr_ready_i && !branch_i) begin
                check("deliv_pc", instr_pc_o, exp_pc);
                check("deliv_data", instr_rdata_o, mem_f(exp_pc));
                last_pc = instr_pc_o;
                exp_pc  = exp_pc + 32'd4;
                deliveries++;
            end
            if (branch_i) exp_pc = br_tgt;
            if (instr_req_o && instr_gnt_i) begin
                r.addr = instr_addr_o;
                r.due  = cyc + $urandom_range(lat_min, lat_max);
                mq.push_back(r);
                grants++;
                check("outstanding_max", 32'(mq.size() <= MAXO), 32'd1);
            end
            if (send && !rv_seen) begin
                rv_seen     = 1'b1;
                valid_at_rv = instr_valid_o;
            end
            prev_hold = instr_req_o && !instr_gnt_i;
            prev_addr = instr_addr_o;
        end else begin
            prev_hold = 1'b0;
        end
        if (send) void'(mq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [W-1:0] start);
        rst_req = 1'b1;
        en      = 1'b0;
        br_req  = 1'b0;
        tick();
        tick();
        rst_req    = 1'b0;
        mq.delete();
        prev_hold  = 1'b0;
        rv_seen    = 1'b0;
        deliveries = 0;
        grants     = 0;
        start_pc   = start;
        exp_pc     = start;
    endtask

    task automatic wait_deliv(input int n, input int budget, input string tag);
        int target;
        int k;
        target = deliveries + n;
        k      = 0;
        while (deliveries < target && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(deliveries >= target), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"},   32'(instr_req_o), 32'd0);
        check({tag, "_addr"},  instr_addr_o, 32'd0);
        check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
        check({tag, "_rdata"}, instr_rdata_o, 32'd0);
        check({tag, "_pc"},    instr_pc_o, 32'd0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
    endtask

    initial begin
        int c0;
        int k;

        rst             = 1'b1;
        fetch_en_i      = 1'b0;
        pc_start_addr_i = '0;
        branch_i        = 1'b0;
        branch_addr_i   = '0;
        instr_gnt_i     = 1'b0;
        instr_rvalid_i  = 1'b0;
        instr_rdata_i   = '0;
        instr_ready_i   = 1'b0;
        gnt_always      = 1'b1;
        lat_min         = 1;
        lat_max         = 1;
        ready_mode      = 1;
        br_tgt          = '0;
        start_pc        = '0;
        last_pc         = '0;
        prev_addr       = '0;
        valid_at_rv     = 1'b0;

        // Reset state
        do_reset(32'h100);
        check_zero_outputs("reset");

        // Sequential fetch, gnt always, response one cycle after grant
        en = 1'b1;
        wait_deliv(1, 20, "first_deliv_timeout");
        check("first_pc", last_pc, 32'h100);
        c0 = cyc;
        wait_deliv(6, 30, "steady_timeout");
        check("steady_one_per_cycle", 32'(cyc - c0), 32'd6);
        check("steady_last_pc", last_pc, 32'h118);

        // rvalid -> instr_valid_o latency with an empty FIFO
        do_reset(32'h100);
        ready_mode = 0;
        en         = 1'b1;
        k = 0;
        while (!rv_seen && k < 20) begin
            tick();
            k++;
        end
        check("rv_seen_timeout", 32'(rv_seen), 32'd1);
`ifdef FETCH_BYPASS_EN
        check("valid_same_cycle_as_rvalid", 32'(valid_at_rv), 32'd1);
`else
        check("valid_same_cycle_as_rvalid", 32'(valid_at_rv), 32'd0);
`endif
        check("valid_cycle_after_rvalid", 32'(instr_valid_o), 32'd1);

        // Back-pressure: FIFO fills to exactly its depth, then requests stop
        for (int i = 0; i < 20; i++) tick();
        check("stall_grants", 32'(grants), 32'd4);
        check("stall_req_low", 32'(instr_req_o), 32'd0);
        check("stall_valid", 32'(instr_valid_o), 32'd1);
        ready_mode = 1;
        k = 0;
        while (grants <= 4 && k < 20) begin
            tick();
            k++;
        end
        check("stall_resume", 32'(grants > 4), 32'd1);
        wait_deliv(6, 30, "resume_deliv_timeout");

        // Fetch disable drains outstanding work and keeps the FIFO contents
        do_reset(32'h400);
        ready_mode = 0;
        en         = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        en = 1'b0;
        k = 0;
        while (busy_o && k < 30) begin
            tick();
            k++;
        end
        check("drain_busy", 32'(busy_o), 32'd0);
        check("drain_req", 32'(instr_req_o), 32'd0);
        check("drain_retained", 32'(instr_valid_o), 32'd1);
        ready_mode = 1;
        wait_deliv(4, 20, "drain_deliv_timeout");
        for (int i = 0; i < 3; i++) tick();
        check("drain_fifo_empty", 32'(instr_valid_o), 32'd0);
        check("drain_count", 32'(deliveries), 32'd4);
        check("drain_last_pc", last_pc, 32'h40C);

        // Branch with two responses outstanding
        do_reset(32'h100);
        lat_min = 3;
        lat_max = 3;
        en      = 1'b1;
        k = 0;
        while (mq.size() != 2 && k < 20) begin
            tick();
            k++;
        end
        check("two_outstanding", 32'(mq.size()), 32'd2);
        br_req = 1'b1;
        br_tgt = 32'h200;
        tick();
        br_req = 1'b0;
        wait_deliv(1, 40, "branch_deliv_timeout");
        check("branch_first_pc", last_pc, 32'h200);
        wait_deliv(3, 30, "branch_follow_timeout");

        // Branch in the same cycle as the grant of 0x10C
        do_reset(32'h100);
        lat_min = 1;
        lat_max = 2;
        en      = 1'b1;
        k = 0;
        while (!(instr_req_o && instr_addr_o == 32'h10C) && k < 20) begin
            tick();
            k++;
        end
        check("req_10c_seen", 32'(instr_req_o && instr_addr_o == 32'h10C), 32'd1);
        br_req = 1'b1;
        br_tgt = 32'h300;
        tick();
        br_req = 1'b0;
        wait_deliv(1, 40, "branch_gnt_deliv_timeout");
        check("branch_gnt_first_pc", last_pc, 32'h300);

        // Fetch address wraps past the top of the address space
        do_reset(32'hFFFF_FFF8);
        lat_min = 1;
        lat_max = 1;
        en      = 1'b1;
        wait_deliv(3, 30, "wrap_timeout");
        check("wrap_pc", last_pc, 32'h0000_0000);

        // Reset with two responses in flight; late responses are ignored
        do_reset(32'h100);
        lat_min = 4;
        lat_max = 4;
        en      = 1'b1;
        k = 0;
        while (mq.size() != 2 && k < 20) begin
            tick();
            k++;
        end
        check("rst_two_outstanding", 32'(mq.size()), 32'd2);
        rst_req = 1'b1;
        en      = 1'b0;
        tick();
        rst_req = 1'b0;
        check_zero_outputs("midrst");
        for (int i = 0; i < 8; i++) begin
            tick();
            check("late_rvalid_valid", 32'(instr_valid_o), 32'd0);
        end
        check("late_rvalid_busy", 32'(busy_o), 32'd0);
        check("late_rvalid_deliv", 32'(deliveries), 32'd0);

        // Randomized traffic with random redirects
        do_reset($urandom() & 32'hFFFF_FFFC);
        gnt_always = 1'b0;
        lat_min    = 1;
        lat_max    = 3;
        ready_mode = 2;
        en         = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            br_req = ($urandom_range(0, 39) == 0);
            br_tgt = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        br_req     = 1'b0;
        en         = 1'b0;
        ready_mode = 1;
        k = 0;
        while ((busy_o || instr_valid_o) && k < 200) begin
            tick();
            k++;
        end
        check("random_end_busy", 32'(busy_o), 32'd0);
        check("random_end_valid", 32'(instr_valid_o), 32'd0);
        check("random_end_req", 32'(instr_req_o), 32'd0);
        check("random_delivered_some", 32'(deliveries > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
